// File: rtl/mhd_stream_monitor.sv
// mhd_stream_monitor
//
// Streaming Hamming-distance monitor for approximate-circuit evaluation.
// Each accepted (a, b) pair flows through a three-stage pipeline:
// S1 registers a ^ b, S2 registers its popcount, and S3 folds that distance
// into the run statistics. A run of num_samples pairs is framed by start/done.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   start          begin a run (honoured only in IDLE)
//   num_samples    run length N, latched when start is accepted
//   in_valid       a/b pair valid
//   in_ready       pair accepted this cycle when in_valid is also high
//   a, b           exact and approximate output words
//   busy           high whenever the monitor is not IDLE
//   done           one-cycle pulse once the run results are final
//   viol_cnt       number of samples whose distance exceeds MHD
//   max_hd         largest distance seen in the run
//   hd_sum         sum of all distances in the run
//   first_viol_vld at least one violation seen
//   first_viol_idx 0-based index of the first violating sample

module mhd_stream_monitor #(
  parameter int WIDTH = 34,
  parameter int MHD   = 4,
  parameter int SUM_W = 7,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       viol_cnt,
  output logic [SUM_W-1:0]       max_hd,
  output logic [CNT_W+SUM_W-1:0] hd_sum,
  output logic                   first_viol_vld,
  output logic [CNT_W-1:0]       first_viol_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [SUM_W-1:0] MHD_LIM = SUM_W'(MHD);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept;
  logic             start_ok;
  logic             run_full;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_diff;
  logic [CNT_W-1:0] s1_idx;
  logic [SUM_W-1:0] s1_pop;

  logic             s2_vld;
  logic [SUM_W-1:0] s2_hd;
  logic [CNT_W-1:0] s2_idx;

  assign accept   = in_valid & in_ready;
  assign start_ok = (state == IDLE) & start;

  // The run is full either when every sample is already in, or when this
  // cycle's accept is the last one; the second term lets RUN leave on the
  // very edge of the final accept. acc_cnt < run_len whenever accept is set,
  // so acc_cnt + 1 cannot wrap.
  assign run_full = (acc_cnt == run_len) |
                    (accept & ((acc_cnt + ONE_CNT) == run_len));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DRAIN waits until neither pipeline stage still holds a
  // sample, so the accumulate stage has absorbed everything before DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (run_full) state_next = DRAIN;
      DRAIN:   if (!s1_vld && !s2_vld) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state. in_ready deliberately ignores in_valid.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    ;
      RUN:     begin
                 busy     = 1'b1;
                 in_ready = (acc_cnt < run_len);
               end
      DRAIN:   busy = 1'b1;
      DONE:    begin
                 busy = 1'b1;
                 done = 1'b1;
               end
      default: ;
    endcase
  end

  // Run length and accept counter, both restarted by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_len <= '0;
      acc_cnt <= '0;
    end else if (start_ok) begin
      run_len <= num_samples;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + ONE_CNT;
    end
  end

  // Population count of the S1 difference word.
  always_comb begin
    s1_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1_pop = s1_pop + SUM_W'(s1_diff[i]);
    end
  end

  // S1 and S2 pipeline stages; each carries a valid bit and the sample index
  // so the accumulate stage can record where the first violation occurred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_diff <= '0;
      s1_idx  <= '0;
      s2_vld  <= 1'b0;
      s2_hd   <= '0;
      s2_idx  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_diff <= a ^ b;
        s1_idx  <= acc_cnt;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_hd  <= s1_pop;
        s2_idx <= s1_idx;
      end
    end
  end

  // S3: accumulate run statistics. Previous results hold until a new start
  // is accepted, which clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_cnt       <= '0;
      max_hd         <= '0;
      hd_sum         <= '0;
      first_viol_vld <= 1'b0;
      first_viol_idx <= '0;
    end else if (start_ok) begin
      viol_cnt       <= '0;
      max_hd         <= '0;
      hd_sum         <= '0;
      first_viol_vld <= 1'b0;
      first_viol_idx <= '0;
    end else if (s2_vld) begin
      hd_sum <= hd_sum + (CNT_W+SUM_W)'(s2_hd);
      if (s2_hd > max_hd) begin
        max_hd <= s2_hd;
      end
      if (s2_hd > MHD_LIM) begin
        viol_cnt <= viol_cnt + ONE_CNT;
        if (!first_viol_vld) begin
          first_viol_vld <= 1'b1;
          first_viol_idx <= s2_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_mhd_stream_monitor.sv
// tb_mhd_stream_monitor
//
// Bench for mhd_stream_monitor. A table of runs (stimulus masks plus the
// expected final statistics and done timing) is applied back to back, each
// new start landing in the first IDLE cycle after the previous done. A
// scoreboard queue holds the cumulative statistics expected after each
// accepted sample and is compared two cycles later when the result appears.
// A hand-written sequence covers reset in the middle of a run.

module tb_mhd_stream_monitor;

  localparam int WIDTH = 34;
  localparam int MHD   = 4;
  localparam int SUM_W = 7;
  localparam int CNT_W = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [CNT_W-1:0]       num_samples;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       viol_cnt;
  logic [SUM_W-1:0]       max_hd;
  logic [CNT_W+SUM_W-1:0] hd_sum;
  logic                   first_viol_vld;
  logic [CNT_W-1:0]       first_viol_idx;

  mhd_stream_monitor #(
    .WIDTH(WIDTH), .MHD(MHD), .SUM_W(SUM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_samples(num_samples),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .viol_cnt(viol_cnt),
    .max_hd(max_hd),
    .hd_sum(hd_sum),
    .first_viol_vld(first_viol_vld),
    .first_viol_idx(first_viol_idx)
  );

  typedef struct {
    int                    n;
    logic                  toggle;
    logic                  extra;
    logic                  start_in_run;
    logic [4:0][WIDTH-1:0] masks;
    int                    done_ofs;
    int                    e_viol;
    int                    e_max;
    int                    e_sum;
    int                    e_fvld;
    int                    e_fidx;
  } run_t;

  typedef struct {
    int                     due;
    logic [CNT_W+SUM_W-1:0] sum;
    logic [SUM_W-1:0]       mx;
    logic [CNT_W-1:0]       vc;
    logic                   fv;
    logic [CNT_W-1:0]       fi;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  run_t runs[6];
  run_t rr;

  // Reference model state: cumulative statistics of the current run.
  logic [CNT_W+SUM_W-1:0] m_sum;
  logic [SUM_W-1:0]       m_max;
  logic [CNT_W-1:0]       m_vc;
  logic                   m_fv;
  logic [CNT_W-1:0]       m_fi;
  logic [CNT_W-1:0]       m_idx;

  // Free-running clock and an edge counter used for latency bookkeeping.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_sum = '0;
    m_max = '0;
    m_vc  = '0;
    m_fv  = 1'b0;
    m_fi  = '0;
    m_idx = '0;
  endtask

  // Scoreboard: on every accept, update the model and queue the statistics
  // expected two edges after the accept edge; pop and compare when due.
  always @(negedge clk) begin
    exp_t e;
    int   hd;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      checkOutput("sb_hd_sum", 64'(hd_sum), 64'(e.sum));
      checkOutput("sb_max_hd", 64'(max_hd), 64'(e.mx));
      checkOutput("sb_viol_cnt", 64'(viol_cnt), 64'(e.vc));
      checkOutput("sb_first_viol_vld", 64'(first_viol_vld), 64'(e.fv));
      checkOutput("sb_first_viol_idx", 64'(first_viol_idx), 64'(e.fi));
    end
    if (rst_n && in_valid && in_ready) begin
      hd = $countones(a ^ b);
      m_sum = m_sum + (CNT_W+SUM_W)'(hd);
      if (hd > int'(m_max)) m_max = SUM_W'(hd);
      if (hd > MHD) begin
        m_vc = m_vc + 1'b1;
        if (!m_fv) begin
          m_fv = 1'b1;
          m_fi = m_idx;
        end
      end
      m_idx = m_idx + 1'b1;
      e.due = cyc + 3;
      e.sum = m_sum;
      e.mx  = m_max;
      e.vc  = m_vc;
      e.fv  = m_fv;
      e.fi  = m_fi;
      sb_q.push_back(e);
    end
  end

  task automatic set_run(input int idx, input int n, input logic tg, input logic ex,
                         input logic sir, input logic [WIDTH-1:0] m0, input logic [WIDTH-1:0] m1,
                         input logic [WIDTH-1:0] m2, input logic [WIDTH-1:0] m3,
                         input logic [WIDTH-1:0] m4, input int ofs, input int vc, input int mx,
                         input int sm, input int fv, input int fi);
    runs[idx].n            = n;
    runs[idx].toggle       = tg;
    runs[idx].extra        = ex;
    runs[idx].start_in_run = sir;
    runs[idx].masks[0]     = m0;
    runs[idx].masks[1]     = m1;
    runs[idx].masks[2]     = m2;
    runs[idx].masks[3]     = m3;
    runs[idx].masks[4]     = m4;
    runs[idx].done_ofs     = ofs;
    runs[idx].e_viol       = vc;
    runs[idx].e_max        = mx;
    runs[idx].e_sum        = sm;
    runs[idx].e_fvld       = fv;
    runs[idx].e_fidx       = fi;
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    return WIDTH'({$urandom(), $urandom()});
  endfunction

  // One complete run: start in the current/next IDLE cycle, feed the samples,
  // wait for done and compare the final statistics and done timing.
  task automatic applyStimulus(input run_t r);
    int acc;
    int step;
    int t;
    int dcyc;
    bit got;
    @(posedge clk); #1;
    start       = 1'b1;
    num_samples = CNT_W'(r.n);
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_done", 64'(done), 64'd0);
    checkOutput("hold_viol_cnt", 64'(viol_cnt), 64'(m_vc));
    checkOutput("hold_hd_sum", 64'(hd_sum), 64'(m_sum));
    @(posedge clk); #1;
    t = cyc;
    start = 1'b0;
    model_clear();
    #1;
    checkOutput("start_busy", 64'(busy), 64'd1);
    checkOutput("start_clr_hd_sum", 64'(hd_sum), 64'd0);
    checkOutput("start_clr_fvld", 64'(first_viol_vld), 64'd0);
    acc  = 0;
    step = 0;
    while (acc < r.n && step < 100) begin
      in_valid = r.toggle ? (step % 2 == 0) : 1'b1;
      a = rand_word();
      b = a ^ r.masks[acc];
      start = r.start_in_run && (step == 0);
      if (r.start_in_run && step == 0) num_samples = CNT_W'(7);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      step++;
    end
    start       = 1'b0;
    num_samples = CNT_W'(r.n);
    checkOutput("accept_count", 64'(acc), 64'(r.n));
    in_valid = r.extra;
    got  = 1'b0;
    dcyc = 0;
    for (int w = 0; w < 30 && !got; w++) begin
      a = rand_word();
      b = ~a;
      @(negedge clk);
      checkOutput("ready_low_after_run", 64'(in_ready), 64'd0);
      if (done) begin
        got  = 1'b1;
        dcyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    checkOutput("done_seen", 64'(got), 64'd1);
    checkOutput("done_time", 64'(dcyc - t), 64'(r.done_ofs));
    checkOutput("final_viol_cnt", 64'(viol_cnt), 64'(r.e_viol));
    checkOutput("final_max_hd", 64'(max_hd), 64'(r.e_max));
    checkOutput("final_hd_sum", 64'(hd_sum), 64'(r.e_sum));
    checkOutput("final_first_viol_vld", 64'(first_viol_vld), 64'(r.e_fvld));
    checkOutput("final_first_viol_idx", 64'(first_viol_idx), 64'(r.e_fidx));
    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_viol_cnt"}, 64'(viol_cnt), 64'd0);
    checkOutput({tag, "_max_hd"}, 64'(max_hd), 64'd0);
    checkOutput({tag, "_hd_sum"}, 64'(hd_sum), 64'd0);
    checkOutput({tag, "_fvld"}, 64'(first_viol_vld), 64'd0);
    checkOutput({tag, "_fidx"}, 64'(first_viol_idx), 64'd0);
  endtask

  initial begin
    // N, toggle, extra, start_in_run, masks[0..4], done offset, viol, max, sum, fvld, fidx
    set_run(0, 4, 0, 0, 0, '0, '0, '0, '0, '0, 7, 0, 0, 0, 0, 0);
    set_run(1, 3, 0, 0, 0, 34'h1F, 34'hF, 34'h3_FFFF_FFFF, '0, '0, 6, 2, 34, 43, 1, 0);
    set_run(2, 5, 1, 1, 0, 34'h1, 34'h3F, 34'h0, 34'hFF, 34'h7, 12, 2, 8, 18, 1, 1);
    set_run(3, 0, 0, 0, 0, '0, '0, '0, '0, '0, 2, 0, 0, 0, 0, 0);
    set_run(4, 2, 0, 0, 1, 34'h1F0, 34'hF000, '0, '0, '0, 5, 1, 5, 9, 1, 0);
    set_run(5, 2, 0, 0, 0, 34'h0, 34'h3_0000_0007, '0, '0, '0, 5, 1, 5, 5, 1, 1);

    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(runs[i]);
    end

    // Reset after the second accept of an N=8 run full of violations.
    @(posedge clk); #1;
    start       = 1'b1;
    num_samples = CNT_W'(8);
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = rand_word();
      b = a ^ 34'hFF;
      @(posedge clk); #1;
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    check_all_zero("midrun_reset");
    rst_n = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("post_reset_flushed");

    // N=1 with hd 6 after the interrupted run.
    rr.n            = 1;
    rr.toggle       = 1'b0;
    rr.extra        = 1'b0;
    rr.start_in_run = 1'b0;
    rr.masks        = '0;
    rr.masks[0]     = 34'h2_0000_001F;
    rr.done_ofs     = 4;
    rr.e_viol       = 1;
    rr.e_max        = 6;
    rr.e_sum        = 6;
    rr.e_fvld       = 1;
    rr.e_fidx       = 0;
    applyStimulus(rr);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
